// File: rtl/memo_pkg.sv
// Shared lane types for the memo stream buffer: one 6-bit lane is a 4-bit
// unsigned high part and a 2-bit signed low part.
package memo_pkg;

  localparam int MEMO_HI_W = 4;
  localparam int MEMO_LO_W = 2;
  localparam int MEMO_W    = MEMO_HI_W + MEMO_LO_W;

  typedef struct packed {
    logic        [MEMO_HI_W-1:0] parts_hi;
    logic signed [MEMO_LO_W-1:0] parts_lo;
  } memo_struct_t;

  typedef logic [MEMO_W-1:0] memo_lane_t;

  // Disabled lanes are stored as all-zero so stale bits never reach the consumer.
  function automatic memo_struct_t mask_lane(input memo_struct_t lane, input logic en);
    return en ? lane : memo_struct_t'('0);
  endfunction

endpackage

// File: rtl/memo_lane_sum.sv
// Masked, sign-extending reduction of the signed low parts of NUM_CH lanes.
module memo_lane_sum
  import memo_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SUM_W  = MEMO_LO_W + $clog2(NUM_CH) + 1
) (
  input  logic        [NUM_CH*MEMO_LO_W-1:0] lo_bits,
  input  logic        [NUM_CH-1:0]           lane_en,
  output logic signed [SUM_W-1:0]            lo_sum
);

  // SUM_W leaves headroom for NUM_CH lanes at -2, so the sum is always exact.
  always_comb begin
    lo_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane_en[i]) begin
        lo_sum = lo_sum + SUM_W'($signed(lo_bits[i*MEMO_LO_W +: MEMO_LO_W]));
      end
    end
  end

endmodule

// File: rtl/memo_stream_buffer.sv
// DEPTH-entry valid/ready FIFO of NUM_CH-lane memo_struct_t entries with lane
// masks, head replay (hold_mode), overflow flag and a signed low-part reduction.
module memo_stream_buffer
  import memo_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = DEPTH - 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic        [NUM_CH*MEMO_W-1:0]        in_data,
  input  logic        [NUM_CH-1:0]               in_lane_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic        [NUM_CH*MEMO_W-1:0]        out_data,
  output logic        [NUM_CH-1:0]               out_lane_en,
  output logic signed [MEMO_LO_W+$clog2(NUM_CH):0] out_lo_sum,
  output logic        [$clog2(DEPTH):0]          level,
  output logic                                   almost_full,
  input  logic                                   hold_mode,
  output logic                                   overflow_sticky,
  input  logic                                   clr_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = MEMO_LO_W + $clog2(NUM_CH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_TH);

  memo_struct_t [NUM_CH-1:0] mem      [DEPTH];
  logic         [NUM_CH-1:0] mask_mem [DEPTH];

  logic         [PTR_W-1:0]            wr_ptr;
  logic         [PTR_W-1:0]            rd_ptr;
  memo_struct_t [NUM_CH-1:0]           in_lanes;
  memo_struct_t [NUM_CH-1:0]           wr_lanes;
  memo_struct_t [NUM_CH-1:0]           head_lanes;
  logic         [NUM_CH*MEMO_LO_W-1:0] head_lo;
  logic         [NUM_CH-1:0]           sum_en;
  logic                                push;
  logic                                pop;

  assign in_lanes    = in_data;
  assign in_ready    = (level != FULL_LVL);
  assign out_valid   = (level != '0);
  assign almost_full = (level >= AF_LVL);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready && !hold_mode;

  assign head_lanes  = mem[rd_ptr];
  assign out_data    = head_lanes;
  assign out_lane_en = mask_mem[rd_ptr];
  // An empty buffer still shows a stale head slot; gate the mask so the sum reads 0.
  assign sum_en      = out_valid ? out_lane_en : '0;

  always_comb begin
    wr_lanes = '0;
    head_lo  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_lanes[i]                         = mask_lane(in_lanes[i], in_lane_en[i]);
      head_lo[i*MEMO_LO_W +: MEMO_LO_W]   = head_lanes[i].parts_lo;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      overflow_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]      <= '0;
        mask_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr]      <= wr_lanes;
        mask_mem[wr_ptr] <= in_lane_en;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (in_valid && !in_ready) begin
        overflow_sticky <= 1'b1;
      end else if (clr_sticky) begin
        overflow_sticky <= 1'b0;
      end
    end
  end

  memo_lane_sum #(
    .NUM_CH (NUM_CH),
    .SUM_W  (SUM_W)
  ) u_lane_sum (
    .lo_bits (head_lo),
    .lane_en (sum_en),
    .lo_sum  (out_lo_sum)
  );

endmodule

// File: tb/tb_memo_stream_buffer.sv
// Directed plus randomized bench for memo_stream_buffer against a queue-based
// reference model of the FIFO, sticky flag and masked low-part sum.
module tb_memo_stream_buffer;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int AF_TH = DEPTH - 1;
  localparam int DW    = NCH * 6;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_data;
  logic [NCH-1:0]          in_lane_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           out_data;
  logic [NCH-1:0]          out_lane_en;
  logic signed [3:0]       out_lo_sum;
  logic [2:0]              level;
  logic                    almost_full;
  logic                    hold_mode;
  logic                    overflow_sticky;
  logic                    clr_sticky;

  memo_stream_buffer #(.NUM_CH(NCH), .DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_lane_en      (in_lane_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_lane_en     (out_lane_en),
    .out_lo_sum      (out_lo_sum),
    .level           (level),
    .almost_full     (almost_full),
    .hold_mode       (hold_mode),
    .overflow_sticky (overflow_sticky),
    .clr_sticky      (clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  d;
    logic [NCH-1:0] en;
  } ent_t;

  ent_t q[$];
  logic sticky_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] masked(input logic [DW-1:0] d, input logic [NCH-1:0] en);
    logic [DW-1:0] r = d;
    for (int i = 0; i < NCH; i++) if (!en[i]) r[i*6 +: 6] = 6'b0;
    return r;
  endfunction

  function automatic int lo_sum_of(input ent_t e);
    int s = 0;
    for (int i = 0; i < NCH; i++) begin
      logic signed [1:0] lo;
      lo = e.d[i*6 +: 2];
      if (e.en[i]) s += int'(lo);
    end
    return s;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":level"},     32'(level),           32'(q.size()));
    chk({tag, ":out_valid"}, 32'(out_valid),       32'(q.size() != 0));
    chk({tag, ":in_ready"},  32'(in_ready),        32'(q.size() != DEPTH));
    chk({tag, ":af"},        32'(almost_full),     32'(q.size() >= AF_TH));
    chk({tag, ":sticky"},    32'(overflow_sticky), 32'(sticky_m));
    if (q.size() != 0) begin
      chk({tag, ":data"}, 32'(out_data),    32'(q[0].d));
      chk({tag, ":en"},   32'(out_lane_en), 32'(q[0].en));
      chk({tag, ":sum"},  32'(out_lo_sum),  32'(lo_sum_of(q[0])));
    end else begin
      chk({tag, ":sum"},  32'(out_lo_sum),  32'(0));
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic [NCH-1:0] en, input logic rdy, input logic hold,
                      input logic clr);
    bit   do_push, do_pop;
    ent_t e;
    in_valid   = v;
    in_data    = d;
    in_lane_en = en;
    out_ready  = rdy;
    hold_mode  = hold;
    clr_sticky = clr;
    do_push = v && (q.size() != DEPTH);
    do_pop  = (q.size() != 0) && rdy && !hold;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.d  = masked(d, en);
      e.en = en;
      q.push_back(e);
    end
    if (v && !do_push) sticky_m = 1'b1;
    else if (clr)      sticky_m = 1'b0;
    check_all(tag);
  endtask

  logic [DW-1:0] ref_d;
  logic [DW-1:0] rd;
  logic [3:0]    k4;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_lane_en = '0;
    out_ready  = 1'b0;
    hold_mode  = 1'b0;
    clr_sticky = 1'b0;
    sticky_m   = 1'b0;
    #2;
    check_all("reset");
    chk("reset:data", 32'(out_data), 32'(0));
    chk("reset:en",   32'(out_lane_en), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lane1 {hi=3, lo=01}, lane0 {hi=A, lo=11}
    ref_d = {4'h3, 2'b01, 4'hA, 2'b11};
    step("push_full_en", 1'b1, ref_d, 2'b11, 1'b0, 1'b0, 1'b0);
    step("pop1",         1'b0, '0,    2'b00, 1'b1, 1'b0, 1'b0);
    step("push_lane0",   1'b1, ref_d, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("lane0:data", 32'(out_data), 32'(12'h02B));
    chk("lane0:sum",  32'(out_lo_sum), 32'(-1));
    step("pop2",         1'b0, '0,    2'b00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      rd = DW'($urandom);
      step("fill", 1'b1, rd, NCH'($urandom), 1'b0, 1'b0, 1'b0);
    end
    rd = DW'($urandom);
    step("overflow",  1'b1, rd, 2'b11, 1'b0, 1'b0, 1'b0);
    step("clr_stick", 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    step("drain",     1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    step("drain",     1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rd = DW'($urandom);
      k4 = 4'(k);
      rd[5:2] = k4;
      step("stream", 1'b1, rd, {1'($urandom), 1'b1}, 1'b1, 1'b0, 1'b0);
    end

    for (int k = 0; k < 3; k++) step("hold", 1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    step("unhold", 1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);

    step("to3", 1'b1, DW'($urandom), 2'b11, 1'b0, 1'b0, 1'b0);
    step("to3", 1'b1, DW'($urandom), 2'b10, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    sticky_m = 1'b0;
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    step("post_rst", 1'b1, ref_d, 2'b11, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      step("rand", 1'($urandom_range(0, 99) < 60), DW'($urandom), NCH'($urandom),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
